// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: single-accumulator machine with a synchronous
// external memory port and a valid/ready input port.
module acc_cpu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] acc,
  output logic              Aeq0,
  output logic              Apos,
  output logic              carry,
  output logic              overflow,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int unsigned MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_INWAIT, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_IN, OP_JZ, OP_JPOS, OP_HALT
  } op_t;

  state_t            state;
  state_t            state_nx;
  op_t               ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              add_ovf;
  logic              sub_ovf;

  // Arithmetic against the word returned by memory in WB
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, mem_rdata};
    diff    = {1'b0, acc} - {1'b0, mem_rdata};
    add_ovf = (acc[MSB] == mem_rdata[MSB]) && (sum[MSB] != acc[MSB]);
    sub_ovf = (acc[MSB] != mem_rdata[MSB]) && (diff[MSB] != acc[MSB]);
  end

  assign Aeq0      = (acc == '0);
  assign Apos      = ~acc[MSB];
  assign mem_wdata = acc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next state and strobes; strobes are forced low while reset is held
  always_comb begin
    state_nx = state;
    mem_addr = pc;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    in_ready = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_re   = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (ir_op)
          OP_LOAD, OP_ADD, OP_SUB: begin
            mem_addr = ir_addr;
            mem_re   = 1'b1;
            state_nx = S_WB;
          end
          OP_STORE: begin
            mem_addr = ir_addr;
            mem_we   = 1'b1;
            state_nx = S_FETCH;
          end
          OP_IN:   state_nx = S_INWAIT;
          OP_HALT: state_nx = S_HALT;
          default: state_nx = S_FETCH;
        endcase
      end
      S_WB: state_nx = S_FETCH;
      S_INWAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase
    if (!rst_n) begin
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      in_ready = 1'b0;
      halted   = 1'b0;
    end
  end

  // Datapath: instruction register, program counter, accumulator and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_op    <= OP_LOAD;
      ir_addr  <= '0;
      pc       <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          ir_op   <= op_t'(mem_rdata[MSB -: 3]);
          ir_addr <= mem_rdata[ADDR_W-1:0];
          pc      <= pc + ADDR_W'(1);
        end
        S_EXEC: begin
          if (ir_op == OP_JZ && acc == '0)    pc <= ir_addr;
          if (ir_op == OP_JPOS && !acc[MSB])  pc <= ir_addr;
        end
        S_WB: begin
          case (ir_op)
            OP_LOAD: acc <= mem_rdata;
            OP_ADD: begin
              acc      <= sum[DATA_W-1:0];
              carry    <= sum[DATA_W];
              overflow <= add_ovf;
            end
            OP_SUB: begin
              acc      <= diff[DATA_W-1:0];
              carry    <= diff[DATA_W];
              overflow <= sub_ovf;
            end
            default: ;
          endcase
        end
        S_INWAIT: if (in_valid) acc <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: behavioural synchronous memory, directed programs,
// scoreboard of expected stores and final halt state checked by a monitor.
module tb_acc_cpu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] mem_addr;
  logic       mem_re, mem_we;
  logic [7:0] mem_wdata, mem_rdata, in_data, acc;
  logic       in_valid, in_ready, Aeq0, Apos, carry, overflow, halted;
  logic [4:0] pc;

  acc_cpu_core #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .acc(acc), .Aeq0(Aeq0), .Apos(Apos), .carry(carry),
    .overflow(overflow), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Synchronous memory; prog is copied in while load is high
  logic [7:0] mem  [0:31];
  logic [7:0] prog [0:31];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= prog[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    bit         is_halt;
    logic [4:0] addr;
    logic [7:0] data;
    logic       c, v, z, p;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_store(input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    e = '{is_halt: 1'b0, addr: a, data: d, c: 1'b0, v: 1'b0, z: 1'b0, p: 1'b0};
    sb.push_back(e);
  endtask

  task automatic push_halt(input logic [7:0] a, input logic c, input logic v,
                           input logic [4:0] p_c, input logic z, input logic p);
    exp_t e;
    e = '{is_halt: 1'b1, addr: p_c, data: a, c: c, v: v, z: z, p: p};
    sb.push_back(e);
  endtask

  // Monitor: pops an expectation on each store strobe and on halt entry
  logic prev_halted = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_store", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("store_kind", 32'(e.is_halt), 32'd0);
        chk("store_addr", 32'(mem_addr), 32'(e.addr));
        chk("store_data", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (halted && !prev_halted) begin
      if (sb.size() == 0) begin
        chk("unexpected_halt", 32'(pc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("halt_kind", 32'(e.is_halt), 32'd1);
        chk("halt_acc", 32'(acc), 32'(e.data));
        chk("halt_carry", 32'(carry), 32'(e.c));
        chk("halt_ovf", 32'(overflow), 32'(e.v));
        chk("halt_pc", 32'(pc), 32'(e.addr));
        chk("halt_aeq0", 32'(Aeq0), 32'(e.z));
        chk("halt_apos", 32'(Apos), 32'(e.p));
      end
    end
    prev_halted = halted;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  // Hold reset, copy the program in, release on a falling edge
  task automatic start_prog();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #1;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 80) begin
      step(1);
      n++;
    end
    chk(name, 32'(halted), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_acc"}, 32'(acc), 32'h00);
    chk({tag, "_pc"}, 32'(pc), 32'h00);
    chk({tag, "_carry"}, 32'(carry), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_aeq0"}, 32'(Aeq0), 32'd1);
    chk({tag, "_apos"}, 32'(Apos), 32'd1);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #1;
    check_reset_vals("reset");

    // LOAD 10, ADD 11, STORE 12, HALT: 5+3 stored, halted after 14 edges
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'h4B; prog[2] = 8'h2C; prog[3] = 8'hE0;
    prog[10] = 8'h05; prog[11] = 8'h03;
    push_store(5'd12, 8'h08);
    push_halt(8'h08, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
    start_prog();
    step(13);
    chk("basic_not_halted_13", 32'(halted), 32'd0);
    step(1);
    chk("basic_halted_14", 32'(halted), 32'd1);
    wait_halt("basic_halt_timeout");
    chk("basic_mem12", 32'(mem[12]), 32'h08);

    // 7F + 01: signed overflow, no carry
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'h4B; prog[2] = 8'hE0;
    prog[10] = 8'h7F; prog[11] = 8'h01;
    push_halt(8'h80, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    start_prog();
    wait_halt("add_ovf_timeout");

    // 00 - 01: borrow, no overflow
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'h6B; prog[2] = 8'hE0;
    prog[10] = 8'h00; prog[11] = 8'h01;
    push_halt(8'hFF, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    start_prog();
    wait_halt("sub_borrow_timeout");

    // JZ taken to 7, then JPOS with A=80 not taken
    clear_prog();
    prog[0] = 8'h14; prog[1] = 8'hA7; prog[2] = 8'hE0;
    prog[7] = 8'h15; prog[8] = 8'hC2; prog[9] = 8'h36; prog[10] = 8'hE0;
    prog[20] = 8'h00; prog[21] = 8'h80;
    push_store(5'd22, 8'h80);
    push_halt(8'h80, 1'b0, 1'b0, 5'd11, 1'b0, 1'b0);
    start_prog();
    step(7);
    chk("jz_taken_pc", 32'(pc), 32'd7);
    step(7);
    chk("jpos_not_taken_pc", 32'(pc), 32'd9);
    wait_halt("jump_timeout");

    // IN waits five cycles, then takes A5 in one edge
    clear_prog();
    prog[0] = 8'h80; prog[1] = 8'h2C; prog[2] = 8'hE0;
    push_store(5'd12, 8'hA5);
    push_halt(8'hA5, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
    start_prog();
    step(3);
    for (int i = 0; i < 5; i++) begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      step(1);
    end
    chk("in_wait_acc_held", 32'(acc), 32'h00);
    in_valid = 1'b1;
    in_data = 8'hA5;
    step(1);
    chk("in_acc", 32'(acc), 32'hA5);
    chk("in_ready_drop", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_halt("in_timeout");

    // Non-jump at address 31 wraps the PC to 0
    clear_prog();
    prog[0] = 8'hBF; prog[1] = 8'hE0; prog[31] = 8'h14; prog[20] = 8'h33;
    push_halt(8'h33, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1);
    start_prog();
    step(3);
    chk("wrap_jz_pc", 32'(pc), 32'd31);
    step(2);
    chk("wrap_pc0", 32'(pc), 32'd0);
    wait_halt("wrap_timeout");

    // Reset during STORE EXEC aborts the write and restarts at address 0
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'h2C; prog[2] = 8'hE0;
    prog[10] = 8'h5A; prog[12] = 8'h11;
    push_store(5'd12, 8'h5A);
    push_halt(8'h5A, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1);
    start_prog();
    step(6);
    chk("abort_store_we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    step(1);
    @(negedge clk);
    chk("abort_mem12_kept", 32'(mem[12]), 32'h11);
    rst_n = 1'b1;
    #1;
    chk("restart_fetch_re", 32'(mem_re), 32'd1);
    chk("restart_fetch_addr", 32'(mem_addr), 32'd0);
    wait_halt("restart_timeout");
    chk("restart_mem12", 32'(mem[12]), 32'h5A);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
